// File: rtl/rom_loader_if.sv
// Boot-link byte stream in, ROM write port and load status out.
// master is the loader side; slave is the byte source / memory / core side.
interface rom_loader_if #(
  parameter int WORD_LENGTH = 32,
  parameter int XLEN        = 32
);
  logic                   Load_Start;
  logic [7:0]             Rx_Data;
  logic                   Rx_Valid;
  logic                   Rx_Ready;
  logic                   Wr_En;
  logic [XLEN-1:0]        Wr_Addr;
  logic [WORD_LENGTH-1:0] Wr_Data;
  logic                   Cpu_Hold;
  logic                   Load_Done;
  logic                   Load_Err;

  modport master (
    input  Load_Start, Rx_Data, Rx_Valid,
    output Rx_Ready, Wr_En, Wr_Addr, Wr_Data, Cpu_Hold, Load_Done, Load_Err
  );

  modport slave (
    output Load_Start, Rx_Data, Rx_Valid,
    input  Rx_Ready, Wr_En, Wr_Addr, Wr_Data, Cpu_Hold, Load_Done, Load_Err
  );
endinterface

// File: rtl/rom_loader.sv
// Boot loader: parses SYNC / count / data / XOR-checksum frames and writes
// little-endian instruction words to sequential ROM addresses from 0.
module rom_loader #(
  parameter int         WORD_LENGTH = 32,
  parameter int         ROM_DEPTH   = 2048,
  parameter int         XLEN        = 32,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input logic         clk,
  input logic         Loader_Rst,
  rom_loader_if.master bus
);

  localparam int BYTES  = WORD_LENGTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_LANE = BIDX_W'(BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_CNT_L, S_CNT_H, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t                 state, state_next;
  logic                   rx_ready, wr_en, cpu_hold, accept;
  logic                   n_bad, last_word, last_lane;
  logic [31:0]            n_hdr;
  logic [7:0]             cnt_lo;
  logic [15:0]            word_cnt, word_idx;
  logic [BIDX_W-1:0]      byte_idx;
  logic [7:0]             checksum;
  logic [XLEN-1:0]        wr_addr;
  logic [WORD_LENGTH-1:0] wr_data;

  assign rx_ready  = (state == S_SYNC) || (state == S_CNT_L) || (state == S_CNT_H) ||
                     (state == S_DATA) || (state == S_CHK);
  assign cpu_hold  = rx_ready || (state == S_WRITE);
  assign wr_en     = (state == S_WRITE);
  assign accept    = bus.Rx_Valid && rx_ready;

  // Count is checked at full 32-bit width so large N never aliases into range.
  assign n_hdr     = {16'd0, bus.Rx_Data, cnt_lo};
  assign n_bad     = (n_hdr == 32'd0) || (n_hdr > 32'(ROM_DEPTH));
  assign last_word = (word_idx == word_cnt - 16'd1);
  assign last_lane = (byte_idx == LAST_LANE);

  always_ff @(posedge clk) begin
    if (Loader_Rst) state <= S_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (bus.Load_Start) state_next = S_SYNC;
      S_SYNC:  if (accept && (bus.Rx_Data == SYNC_BYTE)) state_next = S_CNT_L;
      S_CNT_L: if (accept) state_next = S_CNT_H;
      S_CNT_H: if (accept) state_next = n_bad ? S_ERR : S_DATA;
      S_DATA:  if (accept && last_lane) state_next = S_WRITE;
      S_WRITE: state_next = last_word ? S_CHK : S_DATA;
      S_CHK:   if (accept) state_next = (bus.Rx_Data == checksum) ? S_DONE : S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Loader_Rst) begin
      cnt_lo   <= '0;
      word_cnt <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      checksum <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.Load_Start) begin
            word_idx <= '0;
            byte_idx <= '0;
            checksum <= '0;
          end
        end
        S_CNT_L: if (accept) cnt_lo <= bus.Rx_Data;
        S_CNT_H: if (accept) word_cnt <= {bus.Rx_Data, cnt_lo};
        S_DATA: begin
          if (accept) begin
            wr_data[8*byte_idx +: 8] <= bus.Rx_Data;
            checksum <= checksum ^ bus.Rx_Data;
            byte_idx <= last_lane ? '0 : byte_idx + BIDX_W'(1);
            // Address is latched with the final byte so it is stable for the write cycle.
            if (last_lane) wr_addr <= XLEN'(word_idx);
          end
        end
        S_WRITE: if (!last_word) word_idx <= word_idx + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.Rx_Ready  = rx_ready;
  assign bus.Wr_En     = wr_en;
  assign bus.Wr_Addr   = wr_addr;
  assign bus.Wr_Data   = wr_data;
  assign bus.Cpu_Hold  = cpu_hold;
  assign bus.Load_Done = (state == S_DONE);
  assign bus.Load_Err  = (state == S_ERR);

endmodule

// File: tb/tb_rom_loader.sv
// Randomized frame bench for rom_loader; a monitor scores every ROM write
// against a queue of expected writes built from the frames sent.
module tb_rom_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rom_loader_if bus ();

  rom_loader dut (
    .clk        (clk),
    .Loader_Rst (rst),
    .bus        (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  wr_t         exp_q[$];
  logic [31:0] words_q[$];
  logic [7:0]  garb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // Write monitor: every Wr_En pulse must match the oldest expected write.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.Wr_En === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                   bus.Wr_Addr, bus.Wr_Data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.Wr_Addr), 64'(e.addr));
          check("wr_data", 64'(bus.Wr_Data), 64'(e.data));
          check("rdy_in_write", 64'(bus.Rx_Ready), 64'd0);
          check("hold_in_write", 64'(bus.Cpu_Hold), 64'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus.Rx_Valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.Rx_Data  = b;
    bus.Rx_Valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.Rx_Ready === 1'b1) break;
      n++;
      if (n > 20) begin
        fail("rx_ready_wait");
        break;
      end
    end
    @(posedge clk); #1;
    bus.Rx_Valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.Load_Start = 1'b1;
    @(posedge clk); #1;
    bus.Load_Start = 1'b0;
  endtask

  task automatic start_load();
    pulse_start();
    @(negedge clk);
    check("hold_after_start", 64'(bus.Cpu_Hold), 64'd1);
    check("done_cleared", 64'(bus.Load_Done), 64'd0);
    check("err_cleared", 64'(bus.Load_Err), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_end(input bit exp_done, input bit exp_err);
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (bus.Cpu_Hold === 1'b0) break;
      c++;
      if (c > 200) begin
        fail("end_wait");
        break;
      end
    end
    check("load_done", 64'(bus.Load_Done), 64'(exp_done));
    check("load_err", 64'(bus.Load_Err), 64'(exp_err));
    check("hold_at_end", 64'(bus.Cpu_Hold), 64'd0);
    check("writes_outstanding", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Reference: header counts outside 1..2048 end in error with no writes;
  // otherwise every word is written in order and the outcome follows the XOR.
  task automatic run_frame(input int n, input bit toggle, input bit corrupt, input int start_at);
    logic [7:0] cs, b, cs_sent;
    logic [15:0] n16;
    bit   n_bad;
    int   k;
    n16   = 16'(n);
    n_bad = (n == 0) || (n > 2048);
    start_load();
    foreach (garb_q[i]) send_byte(garb_q[i], toggle);
    send_byte(8'hA5, toggle);
    send_byte(n16[7:0], toggle);
    send_byte(n16[15:8], toggle);
    if (!n_bad) begin
      cs = 8'h00;
      k  = 0;
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < 4; j++) begin
          b = words_q[i][8*j +: 8];
          if (k == start_at) pulse_start();
          send_byte(b, toggle);
          cs = cs ^ b;
          k++;
        end
        exp_q.push_back('{addr: 32'(i), data: words_q[i]});
      end
      cs_sent = corrupt ? (cs ^ (8'h01 << $urandom_range(0, 7))) : cs;
      send_byte(cs_sent, toggle);
    end
    wait_end(!n_bad && !corrupt, n_bad || corrupt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},  64'(bus.Rx_Ready),  64'd0);
    check({tag, "_wen"},  64'(bus.Wr_En),     64'd0);
    check({tag, "_addr"}, 64'(bus.Wr_Addr),   64'd0);
    check({tag, "_data"}, 64'(bus.Wr_Data),   64'd0);
    check({tag, "_hold"}, 64'(bus.Cpu_Hold),  64'd0);
    check({tag, "_done"}, 64'(bus.Load_Done), 64'd0);
    check({tag, "_err"},  64'(bus.Load_Err),  64'd0);
  endtask

  initial begin : stim
    logic [7:0] g;
    int n;
    bus.Load_Start = 1'b0;
    bus.Rx_Valid   = 1'b0;
    bus.Rx_Data    = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset");

    // Two-word reference load
    words_q = '{32'hfe010113, 32'h00812e23};
    garb_q.delete();
    run_frame(2, 1'b0, 1'b0, -1);

    // Leading garbage before sync
    words_q = '{32'h00008067};
    garb_q  = '{8'h00, 8'hFF, 8'h5A};
    run_frame(1, 1'b0, 1'b0, -1);
    garb_q.delete();

    // Out-of-range counts
    run_frame(0, 1'b0, 1'b0, -1);
    run_frame(2049, 1'b0, 1'b0, -1);

    // Corrupted checksum
    words_q = '{32'hdeadbeef};
    run_frame(1, 1'b0, 1'b1, -1);

    // Toggling valid with a stray Load_Start mid-frame
    words_q = '{32'h11223344, 32'h55667788, 32'h99aabbcc};
    run_frame(3, 1'b1, 1'b0, 5);

    // Reset after two data bytes of word 1
    start_load();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h11, 1'b0);
    exp_q.push_back('{addr: 32'd0, data: 32'h11223344});
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("midrst");
    check("midrst_pending", 64'(exp_q.size()), 64'd0);
    words_q = '{32'hcafef00d, 32'h0badc0de};
    run_frame(2, 1'b0, 1'b0, -1);

    // Random frames
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 5);
      words_q.delete();
      garb_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        garb_q.push_back(g);
      end
      run_frame(n, 1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 4 * n + 4)) - 2);
    end
    garb_q.delete();

    // Full-depth load
    words_q.delete();
    for (int i = 0; i < 2048; i++) words_q.push_back($urandom);
    run_frame(2048, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Write-side counterpart of the program ROM: receives a framed byte stream (boot link) and writes 32-bit instruction words into instruction memory.
- Words are written at sequential word addresses from 0.
- Holds the core (Cpu_Hold) for the whole load and flags completion or error.
- Sits between the boot byte receiver and the ROM write port.

Parameters:
- WORD_LENGTH, 32, instruction word width (multiple of 8; bytes per word = WORD_LENGTH/8).
- ROM_DEPTH, 2048, number of words in the target memory.
- XLEN, 32, address width.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  clock; all logic on posedge.
- Loader_Rst  input  1  synchronous active-high reset.
- Load_Start  input  1  single-cycle pulse; begins a load.
- Rx_Data  input  8  incoming byte.
- Rx_Valid  input  1  Rx_Data valid.
- Rx_Ready  output  1  loader accepts a byte this cycle.
- Wr_En  output  1  memory write strobe, one cycle per word.
- Wr_Addr  output  XLEN  word address of the write.
- Wr_Data  output  WORD_LENGTH  assembled word.
- Cpu_Hold  output  1  core held while loading.
- Load_Done  output  1  sticky; load completed successfully.
- Load_Err  output  1  sticky; load failed.

Behaviour:
- Byte acceptance: a byte is accepted on a posedge where Rx_Valid && Rx_Ready.
- Rx_Valid without Rx_Ready is ignored; the sender holds the byte.
- Frame format: SYNC_BYTE, CNT_L, CNT_H (16-bit word count N, little-endian), N words of 4 bytes each (least-significant byte first), then CHK.
  - CHK is the XOR of all data bytes.
- States: IDLE, SYNC, CNT_L, CNT_H, DATA, WRITE, CHK, DONE, ERR.
- Reset (synchronous, Loader_Rst=1 at posedge): state IDLE; Rx_Ready=0, Wr_En=0, Wr_Addr=0, Wr_Data=0, Cpu_Hold=0, Load_Done=0, Load_Err=0; word index, byte index and checksum cleared.
  - Reset overrides everything, including mid-frame and mid-WRITE. No write is issued on the reset cycle.
- IDLE/DONE/ERR: Rx_Ready=0. Load_Start -> SYNC; clears Load_Done, Load_Err, index, checksum; Cpu_Hold=1 from the next cycle.
- Load_Start in any other state is ignored.
- SYNC: Rx_Ready=1.
  - Accepted byte == SYNC_BYTE -> CNT_L.
  - Any other byte is discarded and the state stays SYNC.
- CNT_L: Rx_Ready=1; accept byte -> low half of N -> CNT_H.
- CNT_H: Rx_Ready=1; accept byte -> high half of N.
  - If N==0 or N>ROM_DEPTH -> ERR.
  - Otherwise -> DATA.
- DATA: Rx_Ready=1.
  - Each accepted byte goes into lane byte_idx (bits 8*byte_idx+7:8*byte_idx) of Wr_Data and is XORed into the checksum; byte_idx increments.
  - On the accept of the last byte -> WRITE, with byte_idx wrapping to 0.
- WRITE: exactly one cycle.
  - Rx_Ready=0, Wr_En=1, Wr_Addr=word index (zero-extended), Wr_Data=assembled word.
  - Next cycle: if index==N-1 -> CHK; else index+1 and -> DATA.
- Wr_En is 0 in every state except WRITE. Wr_Addr and Wr_Data hold their last values otherwise.
- Latency: the write pulse occurs on the cycle after the 4th byte of a word is accepted.
- CHK: Rx_Ready=1; accept byte.
  - Equal to checksum -> DONE (Load_Done=1).
  - Otherwise -> ERR (Load_Err=1).
- Cpu_Hold=1 in SYNC through CHK; 0 in IDLE, DONE and ERR. It deasserts on the same cycle Load_Done or Load_Err asserts.
- Load_Done and Load_Err are never both 1. Both are cleared only by reset or by Load_Start.
- Counter widths: word index is 16 bits; N is compared against ROM_DEPTH at full width (no truncation).

Test Plan:
- Reset then Load_Start; stream A5 02 00 13 01 01 FE 23 2E 81 00 (CHK = XOR of the 8 data bytes).
  - Expect two Wr_En pulses: addr 0 data fe010113, then addr 1 data 00812e23.
  - Expect Load_Done=1, Cpu_Hold 1->0, Load_Err=0.
- Leading garbage 00 FF 5A before A5 with N=1, word 00008067.
  - Expect garbage discarded, a single write addr 0 data 00008067, Load_Done=1.
- Header with N=0, then separately N=2049 (ROM_DEPTH=2048).
  - Expect ERR, Load_Err=1, no Wr_En pulse, Cpu_Hold=0.
- Valid N=1 frame with a corrupted CHK byte.
  - Expect the word still written at addr 0, Load_Err=1, Load_Done=0.
- Rx_Valid toggling 1/0 every cycle during DATA, plus a Load_Start pulse mid-frame.
  - Expect bytes taken only on valid cycles, Load_Start ignored, correct words written.
  - Expect Rx_Ready=0 during each WRITE cycle.
- Loader_Rst asserted after 2 data bytes of word 1.
  - Expect all outputs 0 on the next cycle, no write issued.
  - A fresh Load_Start then completes a full load from addr 0.
